// File: rtl/intersect_monitor_if.sv
// intersect_monitor_if: groups the enable, per-channel request/marker inputs
// and the status/pulse/statistics outputs of intersect_monitor.
// master: the side that drives stimulus and observes results.
// slave : the monitor itself.
interface intersect_monitor_if #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 8
);
  logic                      en;
  logic [NUM_CH-1:0]         start;
  logic [NUM_CH-1:0]         qual;
  logic [NUM_CH-1:0]         a_done;
  logic [NUM_CH-1:0]         b_done;
  logic [NUM_CH-1:0]         busy;
  logic [NUM_CH-1:0]         pass;
  logic [NUM_CH-1:0]         fail;
  logic [2*NUM_CH-1:0]       fail_code;
  logic [CNT_W*NUM_CH-1:0]   len_out;
  logic [CNT_W-1:0]          pass_cnt;
  logic [CNT_W-1:0]          fail_cnt;

  modport master (
    output en, start, qual, a_done, b_done,
    input  busy, pass, fail, fail_code, len_out, pass_cnt, fail_cnt
  );

  modport slave (
    input  en, start, qual, a_done, b_done,
    output busy, pass, fail, fail_code, len_out, pass_cnt, fail_cnt
  );
endinterface

// File: rtl/intersect_monitor.sv
// intersect_monitor: NUM_CH independent monitors. Each attempt starts on a
// start request, must keep qual high, and passes on the first cycle where
// both sequence end markers coincide with a length inside [MIN_LEN, MAX_LEN].
// Drop of qual, a lone end marker, an early coincidence or reaching MAX_LEN
// without a match fails the attempt. Pass/fail are registered one-cycle pulses.
// Optional global pass/fail event counters: define INTERSECT_MONITOR_STATS_EN.
module intersect_monitor #(
  parameter int NUM_CH  = 4,
  parameter int CNT_W   = 8,
  parameter int MIN_LEN = 1,
  parameter int MAX_LEN = 16
) (
  input logic                clk,
  input logic                rst_n,
  intersect_monitor_if.slave bus
);

  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] MIN_L = CNT_W'(MIN_LEN);
  localparam logic [CNT_W-1:0] MAX_L = CNT_W'(MAX_LEN);

  localparam logic [1:0] CODE_NONE     = 2'b00;
  localparam logic [1:0] CODE_QUAL     = 2'b01;
  localparam logic [1:0] CODE_MISMATCH = 2'b10;
  localparam logic [1:0] CODE_TIMEOUT  = 2'b11;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_e;

  state_e             state_q   [NUM_CH];
  state_e             state_d   [NUM_CH];
  logic [CNT_W-1:0]   len_q     [NUM_CH];
  logic [CNT_W-1:0]   len_d     [NUM_CH];
  logic [CNT_W-1:0]   cur_len   [NUM_CH];
  logic [1:0]         code_q    [NUM_CH];
  logic [1:0]         code_d    [NUM_CH];
  logic [CNT_W-1:0]   out_len_q [NUM_CH];
  logic [CNT_W-1:0]   out_len_d [NUM_CH];

  logic [NUM_CH-1:0]  pass_q, pass_d;
  logic [NUM_CH-1:0]  fail_q, fail_d;
  logic [NUM_CH-1:0]  sampled;
  logic [NUM_CH-1:0]  both_done;
  logic [NUM_CH-1:0]  one_done;
  logic [NUM_CH-1:0]  ended;
  logic [NUM_CH-1:0]  busy_c;

  // Per-channel attempt evaluation: decide pass/fail/continue for this cycle.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      state_d[c]   = state_q[c];
      len_d[c]     = len_q[c];
      code_d[c]    = code_q[c];
      out_len_d[c] = out_len_q[c];
      pass_d[c]    = 1'b0;
      fail_d[c]    = 1'b0;

      sampled[c]   = bus.en & ((state_q[c] == ACTIVE) | bus.start[c]);
      cur_len[c]   = (state_q[c] == ACTIVE) ? (len_q[c] + ONE) : ONE;
      both_done[c] = bus.a_done[c] & bus.b_done[c];
      one_done[c]  = bus.a_done[c] ^ bus.b_done[c];

      if (!bus.en) begin
        state_d[c] = IDLE;
      end else if (sampled[c]) begin
        if (!bus.qual[c]) begin
          fail_d[c] = 1'b1;
          code_d[c] = CODE_QUAL;
        end else if (both_done[c] && (cur_len[c] >= MIN_L) && (cur_len[c] <= MAX_L)) begin
          pass_d[c] = 1'b1;
          code_d[c] = CODE_NONE;
        end else if (one_done[c] || (both_done[c] && (cur_len[c] < MIN_L))) begin
          fail_d[c] = 1'b1;
          code_d[c] = CODE_MISMATCH;
        end else if (cur_len[c] == MAX_L) begin
          fail_d[c] = 1'b1;
          code_d[c] = CODE_TIMEOUT;
        end

        if (pass_d[c] || fail_d[c]) begin
          state_d[c]   = IDLE;
          out_len_d[c] = cur_len[c];
        end else begin
          state_d[c] = ACTIVE;
          len_d[c]   = cur_len[c];
        end
      end

      ended[c]  = pass_d[c] | fail_d[c];
      busy_c[c] = rst_n & ((state_q[c] == ACTIVE) | (sampled[c] & ~ended[c]));
    end
  end

  // Channel state, running length, result registers and pulse outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < NUM_CH; c++) begin
        state_q[c]   <= IDLE;
        len_q[c]     <= '0;
        code_q[c]    <= CODE_NONE;
        out_len_q[c] <= '0;
      end
      pass_q <= '0;
      fail_q <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        state_q[c]   <= state_d[c];
        len_q[c]     <= len_d[c];
        code_q[c]    <= code_d[c];
        out_len_q[c] <= out_len_d[c];
      end
      pass_q <= pass_d;
      fail_q <= fail_d;
    end
  end

  assign bus.busy = busy_c;
  assign bus.pass = pass_q;
  assign bus.fail = fail_q;

  // Pack per-channel cause and length into the flat output buses.
  always_comb begin
    bus.fail_code = '0;
    bus.len_out   = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      bus.fail_code[2*c +: 2]      = code_q[c];
      bus.len_out[CNT_W*c +: CNT_W] = out_len_q[c];
    end
  end

`ifdef INTERSECT_MONITOR_STATS_EN
  localparam int SUM_W = CNT_W + 5;
  localparam logic [SUM_W-1:0] CNT_MAX = SUM_W'({CNT_W{1'b1}});

  logic [CNT_W-1:0] pass_cnt_q, pass_cnt_d;
  logic [CNT_W-1:0] fail_cnt_q, fail_cnt_d;
  logic [4:0]       pass_pop, fail_pop;
  logic [SUM_W-1:0] pass_sum, fail_sum;

  // Add the pulses presented this cycle across all channels, saturating.
  always_comb begin
    pass_pop = '0;
    fail_pop = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      pass_pop = pass_pop + {4'b0, pass_q[c]};
      fail_pop = fail_pop + {4'b0, fail_q[c]};
    end
    pass_sum   = SUM_W'(pass_cnt_q) + SUM_W'(pass_pop);
    fail_sum   = SUM_W'(fail_cnt_q) + SUM_W'(fail_pop);
    pass_cnt_d = (pass_sum > CNT_MAX) ? {CNT_W{1'b1}} : pass_sum[CNT_W-1:0];
    fail_cnt_d = (fail_sum > CNT_MAX) ? {CNT_W{1'b1}} : fail_sum[CNT_W-1:0];
  end

  // Global event counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pass_cnt_q <= '0;
      fail_cnt_q <= '0;
    end else begin
      pass_cnt_q <= pass_cnt_d;
      fail_cnt_q <= fail_cnt_d;
    end
  end

  assign bus.pass_cnt = pass_cnt_q;
  assign bus.fail_cnt = fail_cnt_q;
`else
  assign bus.pass_cnt = '0;
  assign bus.fail_cnt = '0;
`endif

endmodule
